// File: rtl/intersection_phase_scheduler.sv
// Two-street intersection sequencer: actuated greens with gap-out/max-out,
// latched pedestrian service and a flash mode entered only through all-red.
module intersection_phase_scheduler #(
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             sensor_a,
  input  logic             sensor_b,
  input  logic             ped_req_a,
  input  logic             ped_req_b,
  input  logic             flash,
  output logic [2:0]       street_a,
  output logic [2:0]       street_b,
  output logic             ped_walk_a,
  output logic             ped_walk_b,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [2:0] {
    ALLRED_A = 3'd0,
    GREEN_A  = 3'd1,
    YELLOW_A = 3'd2,
    ALLRED_B = 3'd3,
    GREEN_B  = 3'd4,
    YELLOW_B = 3'd5,
    FLASH    = 3'd6
  } phase_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [CNT_W-1:0] GMIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GMAX = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YEL  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ARED = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d, elapsed_inc;
  logic             blink_q, blink_d;
  logic             latch_a_q, latch_a_d, latch_b_q, latch_b_d;
  logic             walk_a_q, walk_a_d, walk_b_q, walk_b_d;
  logic [2:0]       lamp_a_q, lamp_a_d, lamp_b_q, lamp_b_d;
  logic             leave_a, leave_b;

  assign elapsed_inc = (elapsed_q >= GMAX) ? GMAX : elapsed_q + ONE;

  // Green exit uses the opposing street's latch as it stood before this cycle.
  assign leave_a = flash
                 || (elapsed_inc >= GMIN && (sensor_b || latch_b_q) && !sensor_a)
                 || (elapsed_inc >= GMAX && (sensor_b || latch_b_q));
  assign leave_b = flash
                 || (elapsed_inc >= GMIN && (sensor_a || latch_a_q) && !sensor_b)
                 || (elapsed_inc >= GMAX && (sensor_a || latch_a_q));

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    phase_d     = phase_q;
    remaining_d = remaining_q;
    elapsed_d   = elapsed_q;
    blink_d     = blink_q;
    latch_a_d   = latch_a_q | ped_req_a;
    latch_b_d   = latch_b_q | ped_req_b;
    walk_a_d    = walk_a_q;
    walk_b_d    = walk_b_q;

    if (tick) begin
      case (phase_q)
        ALLRED_A, ALLRED_B: begin
          if (remaining_q <= ONE) begin
            if (flash)                 phase_d = FLASH;
            else if (phase_q == ALLRED_A) phase_d = GREEN_A;
            else                       phase_d = GREEN_B;
          end else begin
            remaining_d = remaining_q - ONE;
          end
        end
        GREEN_A, GREEN_B: begin
          if ((phase_q == GREEN_A) ? leave_a : leave_b) begin
            phase_d = (phase_q == GREEN_A) ? YELLOW_A : YELLOW_B;
          end else begin
            elapsed_d   = elapsed_inc;
            remaining_d = GMAX - elapsed_inc;
          end
        end
        YELLOW_A, YELLOW_B: begin
          if (remaining_q <= ONE) phase_d = (phase_q == YELLOW_A) ? ALLRED_B : ALLRED_A;
          else                    remaining_d = remaining_q - ONE;
        end
        FLASH: begin
          if (!flash) phase_d = ALLRED_A;
          else        blink_d = ~blink_q;
        end
        default: phase_d = ALLRED_A;
      endcase
    end

    // Entry actions; a same-cycle button press both stays latched and lights walk.
    if (phase_d != phase_q) begin
      case (phase_d)
        ALLRED_A, ALLRED_B: remaining_d = ARED;
        GREEN_A: begin
          elapsed_d   = '0;
          remaining_d = GMAX;
          walk_a_d    = latch_a_q | ped_req_a;
          latch_a_d   = ped_req_a;
        end
        GREEN_B: begin
          elapsed_d   = '0;
          remaining_d = GMAX;
          walk_b_d    = latch_b_q | ped_req_b;
          latch_b_d   = ped_req_b;
        end
        YELLOW_A: begin
          remaining_d = YEL;
          walk_a_d    = 1'b0;
        end
        YELLOW_B: begin
          remaining_d = YEL;
          walk_b_d    = 1'b0;
        end
        FLASH: begin
          remaining_d = '0;
          blink_d     = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lamp_a_d = LAMP_RED;
    lamp_b_d = LAMP_RED;
    case (phase_d)
      GREEN_A:  lamp_a_d = LAMP_GRN;
      YELLOW_A: lamp_a_d = LAMP_YEL;
      GREEN_B:  lamp_b_d = LAMP_GRN;
      YELLOW_B: lamp_b_d = LAMP_YEL;
      FLASH: begin
        lamp_a_d = blink_d ? LAMP_YEL : LAMP_OFF;
        lamp_b_d = blink_d ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= ALLRED_A;
      remaining_q <= ARED;
      elapsed_q   <= '0;
      blink_q     <= 1'b0;
      latch_a_q   <= 1'b0;
      latch_b_q   <= 1'b0;
      walk_a_q    <= 1'b0;
      walk_b_q    <= 1'b0;
      lamp_a_q    <= LAMP_RED;
      lamp_b_q    <= LAMP_RED;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      elapsed_q   <= elapsed_d;
      blink_q     <= blink_d;
      latch_a_q   <= latch_a_d;
      latch_b_q   <= latch_b_d;
      walk_a_q    <= walk_a_d;
      walk_b_q    <= walk_b_d;
      lamp_a_q    <= lamp_a_d;
      lamp_b_q    <= lamp_b_d;
    end
  end

  assign street_a   = lamp_a_q;
  assign street_b   = lamp_b_q;
  assign ped_walk_a = walk_a_q;
  assign ped_walk_b = walk_b_q;
  assign phase      = phase_q;
  assign remaining  = remaining_q;

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Sequences the two-street intersection: decides when street A and street B get right-of-way and drives their 3-bit lamp outputs. Inputs are vehicle sensors, latched pedestrian push-buttons and a night/fault flash request; a 1-cycle `tick` enable sets the time base. It sits directly above the lamp drivers and replaces the fixed-cycle light sequencer as the source of `street_a`/`street_b`.

## Interface
Parameters:
- `GREEN_MIN`, 5, minimum green in ticks (≥1)
- `GREEN_MAX`, 20, maximum green under competing demand (GREEN_MIN ≤ GREEN_MAX < 2^CNT_W)
- `YELLOW_T`, 3, yellow duration in ticks (≥1)
- `ALLRED_T`, 1, all-red clearance in ticks (≥1)
- `CNT_W`, 5, width of timing counter

Ports:
- `clk` in 1: single clock; everything is on its rising edge
- `rst` in 1: asynchronous, active-high reset
- `tick` in 1: time-base enable, one `clk` wide; all timing counts these
- `sensor_a`, `sensor_b` in 1: vehicle present (level)
- `ped_req_a`, `ped_req_b` in 1: pedestrian button (pulse, any width)
- `flash` in 1: flash-mode request (level)
- `street_a`, `street_b` out 3: lamps, one-hot, with [2] red, [1] yellow, [0] green; all-zero is legal only in FLASH
- `ped_walk_a`, `ped_walk_b` out 1: walk signal
- `phase` out 3: current state encoding
- `remaining` out CNT_W: ticks left in timed states; GREEN_MAX−elapsed in green, saturating at 0

## Operation
- States and encodings: ALLRED_A=0, GREEN_A=1, YELLOW_A=2, ALLRED_B=3, GREEN_B=4, YELLOW_B=5, FLASH=6.
- Lamps per state:
  - ALLRED_x: both red.
  - GREEN_A: a=green, b=red.
  - YELLOW_A: a=yellow, b=red.
  - B states mirror the A states.
- Reset values: phase=ALLRED_A, remaining=ALLRED_T, street_a=street_b=3'b100, walks=0, ped latches=0, elapsed=0, blink=0.
- Timed states (YELLOW, ALLRED):
  - Load remaining with the duration on entry.
  - Decrement on each tick.
  - On the tick where remaining==1, transition.
  - The state lasts exactly its duration in ticks.
- Flow: ALLRED_A→GREEN_A→YELLOW_A→ALLRED_B→GREEN_B→YELLOW_B→ALLRED_A.
- Green (shown for A; B is symmetric): elapsed is cleared on entry and incremented per tick, saturating at GREEN_MAX. On a tick, leave to YELLOW_A when any of these holds (e = elapsed after increment):
  - flash=1, regardless of GREEN_MIN;
  - e ≥ GREEN_MIN, B demand present, and sensor_a=0 (gap-out);
  - e ≥ GREEN_MAX and B demand present (max-out).
- B demand = sensor_b | ped_latch_b.
- With no B demand, GREEN_A rests indefinitely; remaining saturates at 0.
- Pedestrian latches:
  - ped_latch_x is set on any cycle ped_req_x=1.
  - On entry to GREEN_x it is cleared, and walk_x is set if it was set.
  - walk_x clears on entry to YELLOW_x.
  - A request during GREEN_x is latched for the next service; it does not re-assert walk.
  - Set has priority over clear in the same cycle: the request stays latched and walk_x is set.
- Flash:
  - Entry happens only from an ALLRED_x expiry with flash=1, to FLASH.
  - Green is truncated as above.
  - YELLOW is never skipped.
  - In FLASH, blink toggles per tick; street_a = blink ? yellow : 0, street_b = blink ? red : 0; walks=0.
  - A tick with flash=0 exits to ALLRED_A, with remaining=ALLRED_T.
  - Ped latches keep accumulating in FLASH.
- `rst` mid-operation immediately (asynchronously) forces reset values; a green lamp never persists past reset assertion.

## Timing
- All outputs are registered. A transition decided on the `tick` cycle is visible on the next `clk` edge, so latency is 1 cycle from tick.
- `flash`, sensors and latches are evaluated in the same cycle as `tick`; values between ticks do not affect timing, except ped latching, which happens on every cycle.
- `tick` asserted for consecutive cycles counts each cycle.
- `tick` during reset is ignored.
- At no cycle are both streets non-red outside FLASH (safety invariant).

## Test plan
- Reset, no demand, tick every 4 clks:
  - ALLRED_A lasts 1 tick, then GREEN_A.
  - GREEN_A holds for 50 ticks; remaining=0; street_b stays 3'b100.
- Competing demand:
  - sensor_a=1, sensor_b=1 held.
  - GREEN_A lasts exactly 20 ticks, YELLOW_A 3 ticks, ALLRED_B 1 tick, then GREEN_B.
- Gap-out:
  - sensor_b=1, sensor_a drops after 2 ticks of green.
  - Green ends at the 5th tick (GREEN_MIN), not earlier.
- Pedestrian pulse:
  - A 1-clk ped_req_b during GREEN_A ends GREEN_A at GREEN_MIN.
  - ped_walk_b=1 throughout GREEN_B and 0 in YELLOW_B.
  - A second pulse during GREEN_B re-serves on the next GREEN_B.
- Flash asserted at green tick 2:
  - Sequence is YELLOW_A (3 ticks) → ALLRED_B → FLASH.
  - In FLASH, street_a alternates 010/000 and street_b alternates 100/000 per tick.
  - Deassert flash → ALLRED_A.
- Async reset mid-YELLOW_B, asserted between clk edges:
  - Outputs are immediately both red with phase=0.
  - After release, the sequence restarts with ALLRED_A.
